// File: rtl/window_stream_ctrl.sv
// Frame sequencer in front of a KxK line/window buffer: gates pixels in, tracks the window centre.
// Define WINDOW_STREAM_CTRL_RESYNC_EN to abort and realign a frame on a start-of-frame seen mid-frame.
module window_stream_ctrl #(
  parameter int COLOR_CHANNEL = 8,
  parameter int KERNEL        = 3,
  parameter int WIDTH_IMAGE   = 6,
  parameter int HEIGHT_IMAGE  = 6,
  localparam int XW = ($clog2(WIDTH_IMAGE)  > 1) ? $clog2(WIDTH_IMAGE)  : 1,
  localparam int YW = ($clog2(HEIGHT_IMAGE) > 1) ? $clog2(HEIGHT_IMAGE) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [3*COLOR_CHANNEL-1:0] i_pixel_data,
  input  logic                       i_pixel_valid,
  input  logic                       i_sof,
  output logic                       o_pixel_ready,
  output logic [3*COLOR_CHANNEL-1:0] o_buf_pixel_data,
  output logic                       o_buf_pixel_ready,
  output logic                       o_buf_clear,
  output logic                       o_window_valid,
  output logic [XW-1:0]              o_center_x,
  output logic [YW-1:0]              o_center_y,
  output logic                       o_frame_done,
  output logic                       o_sync_err
);

  localparam int HK  = KERNEL / 2;
  localparam int N   = WIDTH_IMAGE * HEIGHT_IMAGE;
  localparam int LAT = HK * WIDTH_IMAGE + HK;
  localparam int CW  = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAT_C  = CW'(LAT);
  localparam logic [XW-1:0] X_LO   = XW'(HK);
  localparam logic [XW-1:0] X_HI   = XW'(WIDTH_IMAGE - 1 - HK);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH_IMAGE - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(HK);
  localparam logic [YW-1:0] Y_HI   = YW'(HEIGHT_IMAGE - 1 - HK);

  logic [1:0]    state_q, state_d;
  logic          active_q;
  logic [CW-1:0] push_cnt_q, push_cnt_d, p_next;
  logic [XW-1:0] col_q, col_d, cx_q, cx_d;
  logic [YW-1:0] row_q, row_d, cy_q, cy_d;
  logic          win_q, win_d;
  logic          sof_err, accept, push;

`ifdef WINDOW_STREAM_CTRL_RESYNC_EN
  logic abort_q, abort_d;

  // A misaligned sof is refused here and re-presented by the source once back in IDLE.
  assign sof_err      = (state_q == RUN) & i_pixel_valid & i_sof;
  assign abort_d      = (state_q == DONE) ? 1'b0 : (abort_q | sof_err);
  assign o_frame_done = (state_q == DONE) & ~abort_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) abort_q <= 1'b0;
    else            abort_q <= abort_d;
  end
`else
  assign sof_err      = 1'b0;
  assign o_frame_done = (state_q == DONE);
`endif

  // active_q keeps ready low through the reset cycle itself.
  assign o_pixel_ready     = active_q & (state_q != DONE) & ~sof_err;
  assign accept            = i_pixel_valid & o_pixel_ready;
  assign push              = accept & ((state_q == RUN) | ((state_q == IDLE) & i_sof));
  assign o_buf_pixel_ready = push;
  assign o_buf_pixel_data  = active_q ? i_pixel_data : '0;
  assign o_buf_clear       = (state_q == DONE);
  assign o_sync_err        = sof_err;
  assign o_window_valid    = win_q;
  assign o_center_x        = cx_q;
  assign o_center_y        = cy_q;

  always_comb begin
    // NOTE: every combinational target gets a default first so no path infers a latch.
    state_d    = state_q;
    push_cnt_d = push_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    win_d      = 1'b0;
    p_next     = (state_q == RUN) ? push_cnt_q + 1'b1 : CW'(1);

    case (state_q)
      IDLE: if (push) state_d = RUN;
      RUN: begin
        if (sof_err)                      state_d = DONE;
        else if (push && p_next == N_C)   state_d = DONE;
      end
      DONE: begin
        state_d    = IDLE;
        push_cnt_d = '0;
        col_d      = '0;
        row_d      = '0;
      end
      default: state_d = IDLE;
    endcase

    // The centre trails the push count by LAT; col/row always hold the next centre to emit.
    if (push) begin
      push_cnt_d = p_next;
      if (p_next > LAT_C) begin
        cx_d  = col_q;
        cy_d  = row_q;
        win_d = (col_q >= X_LO) && (col_q <= X_HI) && (row_q >= Y_LO) && (row_q <= Y_HI);
        if (col_q == X_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      active_q   <= 1'b0;
      push_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= 1'b1;
      push_cnt_q <= push_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      win_q      <= win_d;
    end
  end

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Self-checking bench for window_stream_ctrl: vector table, directed frame scenarios, random traffic.
// Expected behaviour comes from a frame-level model using push counts and c = p-1-LAT arithmetic.
module tb_window_stream_ctrl;

  localparam int CC  = 8;
  localparam int K   = 3;
  localparam int W   = 6;
  localparam int HI  = 6;
  localparam int HK  = K / 2;
  localparam int N   = W * HI;
  localparam int LAT = HK * W + HK;
  localparam int INTERIOR = (W - 2 * HK) * (HI - 2 * HK);
  localparam int FIRST_P  = (HK * W + HK) + 1 + LAT;
  localparam int XW = ($clog2(W)  > 1) ? $clog2(W)  : 1;
  localparam int YW = ($clog2(HI) > 1) ? $clog2(HI) : 1;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b1;
  logic [3*CC-1:0]   i_pixel_data = '0;
  logic              i_pixel_valid = 1'b0;
  logic              i_sof = 1'b0;
  logic              o_pixel_ready, o_buf_pixel_ready, o_buf_clear;
  logic [3*CC-1:0]   o_buf_pixel_data;
  logic              o_window_valid, o_frame_done, o_sync_err;
  logic [XW-1:0]     o_center_x;
  logic [YW-1:0]     o_center_y;

  window_stream_ctrl #(
    .COLOR_CHANNEL(CC), .KERNEL(K), .WIDTH_IMAGE(W), .HEIGHT_IMAGE(HI)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_pixel_data(i_pixel_data), .i_pixel_valid(i_pixel_valid), .i_sof(i_sof),
    .o_pixel_ready(o_pixel_ready), .o_buf_pixel_data(o_buf_pixel_data),
    .o_buf_pixel_ready(o_buf_pixel_ready), .o_buf_clear(o_buf_clear),
    .o_window_valid(o_window_valid), .o_center_x(o_center_x), .o_center_y(o_center_y),
    .o_frame_done(o_frame_done), .o_sync_err(o_sync_err)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model state
  bit m_active, m_in_frame, m_clear, m_abort, m_win;
  int m_p, m_cx, m_cy;
  int win_cnt, dut_pushes;

  typedef struct {
    bit          v;
    bit          s;
    logic [23:0] d;
    bit          e_ready;
    bit          e_push;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_in_frame = 0; m_clear = 0; m_abort = 0; m_win = 0;
    m_p = 0; m_cx = 0; m_cy = 0; win_cnt = 0; dut_pushes = 0;
  endtask

  task automatic do_reset();
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_ready",   o_pixel_ready, 0);
    check("rst_bufrdy",  o_buf_pixel_ready, 0);
    check("rst_bufdata", o_buf_pixel_data, 0);
    check("rst_clear",   o_buf_clear, 0);
    check("rst_win",     o_window_valid, 0);
    check("rst_cx",      o_center_x, 0);
    check("rst_cy",      o_center_y, 0);
    check("rst_done",    o_frame_done, 0);
    check("rst_syncerr", o_sync_err, 0);
    model_reset();
    i_pixel_valid = 1'b0; i_sof = 1'b0; i_pixel_data = '0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    #1 check("rel_ready", o_pixel_ready, 0);
    m_active = 1;
  endtask

  // One clock: drive at the falling edge, compare against the model, then advance the model.
  task automatic cycle(input bit v, input bit s, input logic [23:0] d);
    bit e_ready, e_push, e_err;
    int c;
    @(negedge i_clk);
    i_pixel_valid = v; i_sof = s; i_pixel_data = d;
    #1;
    e_err = 0;
`ifdef WINDOW_STREAM_CTRL_RESYNC_EN
    e_err = m_in_frame && !m_clear && v && s;
`endif
    e_ready = m_active && !m_clear && !e_err;
    e_push  = v && e_ready && (m_in_frame || s);
    check("ready",    o_pixel_ready, e_ready);
    check("bufrdy",   o_buf_pixel_ready, e_push);
    check("sync_err", o_sync_err, e_err);
    check("clear",    o_buf_clear, m_clear);
    check("done",     o_frame_done, m_clear && !m_abort);
    check("win",      o_window_valid, m_win);
    check("cx",       o_center_x, m_cx);
    check("cy",       o_center_y, m_cy);
    if (e_push) check("bufdata", o_buf_pixel_data, d);

    if (o_window_valid) begin
      if (win_cnt == 0) begin
        check("first_cx",   o_center_x, HK);
        check("first_cy",   o_center_y, HK);
        check("first_push", dut_pushes, FIRST_P);
      end
      win_cnt++;
    end
    if (o_frame_done) begin
      check("frame_windows", win_cnt, INTERIOR);
      check("frame_pushes",  dut_pushes, N);
      check("last_win",      o_window_valid, 1);
      check("last_cx",       o_center_x, W - 1 - HK);
      check("last_cy",       o_center_y, HI - 1 - HK);
    end
    if (o_buf_clear) begin
      win_cnt = 0;
      dut_pushes = 0;
    end
    if (o_buf_pixel_ready) dut_pushes++;

    m_win = 0;
    if (m_clear) begin
      m_clear = 0; m_in_frame = 0; m_p = 0; m_abort = 0;
    end else if (e_err) begin
      m_clear = 1; m_abort = 1;
    end else if (e_push) begin
      m_p++;
      m_in_frame = 1;
      c = m_p - 1 - LAT;
      if (c >= 0) begin
        m_cx  = c % W;
        m_cy  = c / W;
        m_win = (m_cx >= HK) && (m_cx <= W - 1 - HK) && (m_cy >= HK) && (m_cy <= HI - 1 - HK);
      end
      if (m_p == N) m_clear = 1;
    end
  endtask

  task automatic frame(input int gap_mod);
    for (int i = 0; i < N * gap_mod; i++)
      cycle((i % gap_mod) == 0, i == 0, 24'($urandom));
  endtask

  initial begin
    tbl[0]  = '{v:0, s:0, d:24'h000001, e_ready:1, e_push:0};
    tbl[1]  = '{v:1, s:0, d:24'h111111, e_ready:1, e_push:0};
    tbl[2]  = '{v:1, s:0, d:24'h222222, e_ready:1, e_push:0};
    tbl[3]  = '{v:0, s:1, d:24'h333333, e_ready:1, e_push:0};
    tbl[4]  = '{v:1, s:0, d:24'h444444, e_ready:1, e_push:0};
    tbl[5]  = '{v:1, s:0, d:24'h555555, e_ready:1, e_push:0};
    tbl[6]  = '{v:1, s:0, d:24'h666666, e_ready:1, e_push:0};
    tbl[7]  = '{v:1, s:1, d:24'hA0B0C0, e_ready:1, e_push:1};
    tbl[8]  = '{v:1, s:0, d:24'hA1B1C1, e_ready:1, e_push:1};
    tbl[9]  = '{v:0, s:0, d:24'hA2B2C2, e_ready:1, e_push:0};
    tbl[10] = '{v:1, s:0, d:24'hA3B3C3, e_ready:1, e_push:1};

    model_reset();
    do_reset();

    // Dropped non-sof pixels, then a frame start with a gap
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].d);
      check("tbl_ready",  o_pixel_ready, tbl[i].e_ready);
      check("tbl_bufrdy", o_buf_pixel_ready, tbl[i].e_push);
    end
    for (int i = 0; i < N - 3; i++) cycle(1, 0, 24'($urandom));
    cycle(0, 0, '0);

    // Back-to-back frame, then one with valid toggling every cycle
    frame(1);
    cycle(0, 0, '0);
    frame(2);
    cycle(0, 0, '0);

    // sof presented during the clear cycle is taken one cycle later
    frame(1);
    cycle(1, 1, 24'h5A5A5A);
    check("done_ready", o_pixel_ready, 0);
    check("done_clear", o_buf_clear, 1);
    cycle(1, 1, 24'h5A5A5A);
    check("sof_taken", o_buf_pixel_ready, 1);
    for (int i = 0; i < N - 1; i++) cycle(1, 0, 24'($urandom));
    cycle(0, 0, '0);

    // Reset in the middle of a frame, then a complete frame
    for (int i = 0; i < 20; i++) cycle(1, i == 0, 24'($urandom));
    do_reset();
    frame(1);
    cycle(0, 0, '0);

`ifdef WINDOW_STREAM_CTRL_RESYNC_EN
    for (int i = 0; i < 9; i++) cycle(1, i == 0, 24'($urandom));
    cycle(1, 1, 24'h0F0F0F);
    check("resync_err",   o_sync_err, 1);
    check("resync_ready", o_pixel_ready, 0);
    cycle(1, 1, 24'h0F0F0F);
    check("resync_clear", o_buf_clear, 1);
    check("resync_done",  o_frame_done, 0);
    cycle(1, 1, 24'h0F0F0F);
    check("resync_take",  o_buf_pixel_ready, 1);
    for (int i = 0; i < N - 1; i++) cycle(1, 0, 24'($urandom));
    cycle(0, 0, '0);
`endif

    // Random traffic: valid gaps, stray sof in idle and mid-frame
    for (int i = 0; i < 2000; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = m_in_frame ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
      cycle(v, s, 24'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_stream_ctrl.md
Name: window_stream_ctrl

Overview:
Frame-level sequencer that sits between the pixel source and the KxK line/window buffer.
- Gates the RGB pixel stream into the buffer with a valid/ready handshake and aligns frames on start-of-frame.
- Tracks the raster coordinate of the current window centre.
- Qualifies only windows that lie fully inside the image, so row-wrap windows never reach the filter.
- Clears the buffer between frames with a one-cycle synchronous clear pulse.

Parameters:
COLOR_CHANNEL, 8, bits per colour channel (3 channels per pixel)
KERNEL, 3, window size; odd, >=3
WIDTH_IMAGE, 6, pixels per line; must be > KERNEL
HEIGHT_IMAGE, 6, lines per frame; must be >= KERNEL

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_pixel_data  in  3*COLOR_CHANNEL  RGB pixel from source
i_pixel_valid  in  1  source pixel valid
i_sof  in  1  qualifies i_pixel_data as pixel (0,0) of a frame
o_pixel_ready  out  1  controller can accept a pixel
o_buf_pixel_data  out  3*COLOR_CHANNEL  pixel pushed to window buffer
o_buf_pixel_ready  out  1  push strobe to window buffer
o_buf_clear  out  1  one-cycle synchronous clear to window buffer
o_window_valid  out  1  buffer window is an interior KxK window
o_center_x  out  max(1,$clog2(WIDTH_IMAGE))  centre column of current window
o_center_y  out  max(1,$clog2(HEIGHT_IMAGE))  centre row of current window
o_frame_done  out  1  one-cycle pulse, frame complete
o_sync_err  out  1  one-cycle pulse, sof misalignment (optional feature only)

Behaviour:
- Reset is i_reset_n, asynchronous, active-low; clock is i_clk.
- Reset values: state=IDLE; all outputs 0 (o_pixel_ready=0 only for the reset cycle, then per state); counters 0.
- Accept = i_pixel_valid & o_pixel_ready.
- Constants: N = WIDTH_IMAGE*HEIGHT_IMAGE; H = KERNEL/2; LAT = H*WIDTH_IMAGE + H.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - o_pixel_ready=1.
  - Accept with i_sof=0: pixel dropped, no push.
  - Accept with i_sof=1: pushed, push_cnt=1, go to RUN.
- RUN:
  - o_pixel_ready=1; every accept is pushed and push_cnt increments.
  - On the push that makes push_cnt==N, go to DONE.
  - i_sof is ignored unless the optional feature is enabled.
- DONE (exactly 1 cycle):
  - o_pixel_ready=0, o_buf_clear=1, o_frame_done=1.
  - Counters cleared; next state IDLE.
- Push path is combinational:
  - o_buf_pixel_ready = accept & (RUN | (IDLE & i_sof)).
  - o_buf_pixel_data = i_pixel_data.
- Centre tracking:
  - After the p-th push (1-based), the centre index is c = p-1-LAT.
  - Tracked by registered col/row counters that start once p > LAT.
  - Column wraps at WIDTH_IMAGE-1 to 0 and increments row.
- o_window_valid, o_center_x, o_center_y:
  - Registered; updated on the clock edge of each push, so they align with the buffer's window update.
  - o_window_valid=1 for exactly one cycle when c>=0 and H<=x<=WIDTH_IMAGE-1-H and H<=y<=HEIGHT_IMAGE-1-H.
  - Deasserted on cycles with no push.
  - Coordinates hold their value when there is no push.
- The last interior window (WIDTH_IMAGE-1-H, HEIGHT_IMAGE-1-H) is produced by push N, so no flush is required.
  - Its o_window_valid coincides with the DONE cycle.
- Gaps in i_pixel_valid stall all counters; there is no timeout.
- Reset mid-frame: everything returns to IDLE immediately. o_buf_clear is not asserted; the buffer shares i_reset_n.
- Total interior windows per frame = (WIDTH_IMAGE-2H)*(HEIGHT_IMAGE-2H).

Optional Feature:
WINDOW_STREAM_CTRL_RESYNC_EN
- Defined:
  - Accept with i_sof=1 in RUN (push_cnt between 1 and N-1 inclusive) is not pushed and not consumed.
  - o_pixel_ready drops combinationally that cycle.
  - o_sync_err=1 for one cycle; FSM goes to DONE, where o_buf_clear=1 but o_frame_done=0.
  - Then IDLE, where the still-presented sof pixel is accepted as a new frame.
- Undefined: o_sync_err tied 0; i_sof ignored in RUN.

Test Plan:
1. W=6,H=6,K=3, 36 back-to-back pixels with sof on the first:
   - 16 o_window_valid pulses.
   - First pulse the cycle after push 15 with centre (1,1); last the cycle after push 36 with centre (4,4).
   - o_frame_done and o_buf_clear high in that same cycle.
2. 5 pixels without sof, then a frame: first 5 produce no o_buf_pixel_ready; the frame then behaves as in scenario 1.
3. Frame with i_pixel_valid toggled 1/0 every cycle: same 16 windows and coordinates; o_window_valid never high on a no-push cycle.
4. Two frames back-to-back with sof presented in the DONE cycle: o_pixel_ready=0 that cycle; pixel is accepted next cycle in IDLE; second frame gives 16 windows.
5. Reset asserted after push 20: all outputs 0 asynchronously; after release, a fresh frame yields the full 16 windows.
6. RESYNC_EN defined, sof at push 10: o_sync_err pulse, o_buf_clear pulse, o_frame_done=0; sof pixel is accepted one cycle later and the frame completes normally.
